// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: register width, forwarding select
// codes and the control half of a scoreboard slot record.
package cpu_pipe_pkg;

  localparam int REG_W  = 5;
  localparam int FWD_RF = 0;

  // The immediate code sits just past the last forwarding stage.
  function automatic int fwd_imm(input int fwd_stages);
    return fwd_stages + 1;
  endfunction

  typedef struct packed {
    logic valid;
    logic regwr;
    logic is_load;
  } slot_ctl_t;

endpackage

// File: rtl/fwd_src_match.sv
// Per-operand priority comparator over the in-flight slots.
// Ports: src, slot fields in, sel code and load_blk flag out.
module fwd_src_match #(
  parameter int REG_W      = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = 2
) (
  input  logic [REG_W-1:0]            src,
  input  logic [FWD_STAGES-1:0]       s_valid,
  input  logic [FWD_STAGES-1:0]       s_regwr,
  input  logic [FWD_STAGES-1:0]       s_load,
  input  logic [FWD_STAGES*REG_W-1:0] s_rd,
  output logic [SEL_W-1:0]            sel,
  output logic                        load_blk
);
  import cpu_pipe_pkg::*;

  logic hit;

  // Oldest first, so the youngest match overwrites sel last.
  always_comb begin
    sel      = SEL_W'(FWD_RF);
    load_blk = 1'b0;
    hit      = 1'b0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      hit = s_valid[k] && s_regwr[k] &&
            (s_rd[k*REG_W +: REG_W] == src) &&
            (src != '0);
      if (hit) begin
        sel = SEL_W'(k + 1);
        if (s_load[k] && (k + 1 < LOAD_STAGE))
          load_blk = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall unit with its own
// destination scoreboard. Ports: ID record in; stall, fwd_sel, stall_cnt out.
module fwd_hazard_unit #(
  parameter int REG_W      = cpu_pipe_pkg::REG_W,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ext_stall,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic                     id_regwr,
  input  logic                     id_is_load,
  input  logic [REG_W-1:0]         id_rd,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic                     id_imm_b,
  output logic                     stall,
  output logic [NUM_SRC*$clog2(FWD_STAGES+2)-1:0] fwd_sel,
  output logic [CNT_W-1:0]         stall_cnt
);
  import cpu_pipe_pkg::*;

  localparam int SEL_W = $clog2(FWD_STAGES + 2);
  localparam logic [SEL_W-1:0] SEL_IMM =
    SEL_W'(fwd_imm(FWD_STAGES));

  // Only S[0..FWD_STAGES-1] are kept: the WB-exit slot
  // retires into a write-first regfile and is never read.
  slot_ctl_t        ctl [FWD_STAGES];
  logic [REG_W-1:0] rd  [FWD_STAGES];

  logic [FWD_STAGES-1:0]       s_valid;
  logic [FWD_STAGES-1:0]       s_regwr;
  logic [FWD_STAGES-1:0]       s_load;
  logic [FWD_STAGES*REG_W-1:0] s_rd;

  logic [SEL_W-1:0]         src_sel [NUM_SRC];
  logic [NUM_SRC-1:0]       src_blk;
  logic [NUM_SRC*SEL_W-1:0] sel_next;
  logic [NUM_SRC*SEL_W-1:0] sel_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     id_go;

  always_comb begin
    s_valid = '0;
    s_regwr = '0;
    s_load  = '0;
    s_rd    = '0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      s_valid[k] = ctl[k].valid;
      s_regwr[k] = ctl[k].regwr;
      s_load[k]  = ctl[k].is_load;
      s_rd[k*REG_W +: REG_W] = rd[k];
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .REG_W      (REG_W),
      .FWD_STAGES (FWD_STAGES),
      .LOAD_STAGE (LOAD_STAGE),
      .SEL_W      (SEL_W)
    ) u_match (
      .src      (id_src[i*REG_W +: REG_W]),
      .s_valid  (s_valid),
      .s_regwr  (s_regwr),
      .s_load   (s_load),
      .s_rd     (s_rd),
      .sel      (src_sel[i]),
      .load_blk (src_blk[i])
    );
  end

  // Flush and freeze both suppress the stall request.
  always_comb begin
    stall = (|src_blk) & id_valid & ~flush & ~ext_stall;
    id_go = id_valid & ~flush & ~stall;
  end

  always_comb begin
    sel_next = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i == 1 && id_imm_b)
        sel_next[i*SEL_W +: SEL_W] = SEL_IMM;
      else
        sel_next[i*SEL_W +: SEL_W] = src_sel[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FWD_STAGES; k++) begin
        ctl[k] <= '0;
        rd[k]  <= '0;
      end
      sel_q <= '0;
      cnt_q <= '0;
    end else if (!ext_stall) begin
      for (int k = FWD_STAGES - 1; k >= 1; k--) begin
        ctl[k] <= ctl[k-1];
        rd[k]  <= rd[k-1];
      end
      if (id_go) begin
        ctl[0] <= '{valid: 1'b1, regwr: id_regwr,
                    is_load: id_is_load};
        rd[0]  <= id_rd;
      end else begin
        ctl[0] <= '0;
        rd[0]  <= '0;
      end
      sel_q <= id_go ? sel_next : '0;
      if (stall && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign fwd_sel   = sel_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: two instances
// (2 fwd / load@2 and 3 fwd / load@3) share one stimulus.
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       ext_stall, flush, id_valid;
  logic       id_regwr, id_is_load, id_imm_b;
  logic [4:0] id_rd;
  logic [9:0] id_src;

  logic        stall_a, stall_b;
  logic [3:0]  sel_a;
  logic [5:0]  sel_b;
  logic [15:0] cnt_a, cnt_b;

  fwd_hazard_unit #(
    .REG_W(5), .NUM_SRC(2), .FWD_STAGES(2),
    .LOAD_STAGE(2), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall),
    .flush(flush), .id_valid(id_valid),
    .id_regwr(id_regwr), .id_is_load(id_is_load),
    .id_rd(id_rd), .id_src(id_src), .id_imm_b(id_imm_b),
    .stall(stall_a), .fwd_sel(sel_a), .stall_cnt(cnt_a)
  );

  fwd_hazard_unit #(
    .REG_W(5), .NUM_SRC(2), .FWD_STAGES(3),
    .LOAD_STAGE(3), .CNT_W(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall),
    .flush(flush), .id_valid(id_valid),
    .id_regwr(id_regwr), .id_is_load(id_is_load),
    .id_rd(id_rd), .id_src(id_src), .id_imm_b(id_imm_b),
    .stall(stall_b), .fwd_sel(sel_b), .stall_cnt(cnt_b)
  );

  typedef struct {
    int    cyc;
    bit    dut;
    string name;
    int    st;
    int    a;
    int    b;
    int    cnt;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(string n, string what,
                     logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s actual=%0d required=%0d",
               n, what, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      cmp(m_e.name, "cycle", 32'(cyc), 32'(m_e.cyc));
      if (!m_e.dut) begin
        cmp(m_e.name, "stall", 32'(stall_a), 32'(m_e.st));
        cmp(m_e.name, "selA", 32'(sel_a[1:0]), 32'(m_e.a));
        cmp(m_e.name, "selB", 32'(sel_a[3:2]), 32'(m_e.b));
        cmp(m_e.name, "cnt", 32'(cnt_a), 32'(m_e.cnt));
      end else begin
        cmp(m_e.name, "stall", 32'(stall_b), 32'(m_e.st));
        cmp(m_e.name, "selA", 32'(sel_b[2:0]), 32'(m_e.a));
        cmp(m_e.name, "selB", 32'(sel_b[5:3]), 32'(m_e.b));
        cmp(m_e.name, "cnt", 32'(cnt_b), 32'(m_e.cnt));
      end
    end
  end

  task automatic drv(bit v, bit w, bit l, int rd, int rs,
                     int rt, bit imm, bit fl, bit xs);
    @(posedge clk);
    #1;
    id_valid   = v;
    id_regwr   = w;
    id_is_load = l;
    id_rd      = 5'(rd);
    id_src     = {5'(rt), 5'(rs)};
    id_imm_b   = imm;
    flush      = fl;
    ext_stall  = xs;
  endtask

  task automatic nop(bit xs);
    drv(0, 0, 0, 0, 0, 0, 0, 0, xs);
  endtask

  task automatic alu(int rd, int rs, int rt, bit fl);
    drv(1, 1, 0, rd, rs, rt, 0, fl, 0);
  endtask

  task automatic addi(int rd, int rs, int rt);
    drv(1, 1, 0, rd, rs, rt, 1, 0, 0);
  endtask

  task automatic lw(int rd, int rs);
    drv(1, 1, 1, rd, rs, 0, 1, 0, 0);
  endtask

  task automatic chk(bit d, string n, int st, int a,
                     int b, int cnt);
    exp_t e;
    e.cyc = cyc; e.dut = d; e.name = n;
    e.st = st; e.a = a; e.b = b; e.cnt = cnt;
    q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    ext_stall = 0; flush = 0; id_valid = 0;
    id_regwr = 0; id_is_load = 0; id_imm_b = 0;
    id_rd = '0; id_src = '0;

    nop(0); chk(0, "reset_a", 0, 0, 0, 0);
    chk(1, "reset_b", 0, 0, 0, 0);
    @(negedge clk); #1 rst_n = 1'b1;

    alu(3, 1, 2, 0); chk(0, "t1_idle", 0, 0, 0, 0);
    alu(4, 3, 3, 0); chk(0, "t1_sel0", 0, 0, 0, 0);
    nop(0);          chk(0, "t1_mem", 0, 1, 1, 0);
    alu(3, 1, 2, 0);
    nop(0);
    alu(5, 3, 0, 0);
    nop(0);          chk(0, "t2_wb", 0, 2, 0, 0);
    alu(3, 1, 2, 0);
    alu(3, 1, 2, 0);
    alu(7, 3, 4, 0);
    nop(0);          chk(0, "t2_young", 0, 1, 0, 0);
    lw(2, 8);
    alu(6, 2, 7, 0); chk(0, "t3_stall", 1, 0, 3, 0);
    alu(6, 2, 7, 0); chk(0, "t3_bubble", 0, 0, 0, 1);
    nop(0);          chk(0, "t3_fwd", 0, 2, 0, 1);
    alu(0, 1, 2, 0);
    alu(8, 0, 0, 0);
    alu(9, 1, 2, 0); chk(0, "t4_r0", 0, 0, 0, 1);
    addi(10, 9, 9);
    lw(11, 1);       chk(0, "t4_imm", 0, 1, 3, 1);
    alu(12, 11, 11, 1); chk(0, "t5_flush", 0, 0, 3, 1);
    alu(13, 12, 12, 0); chk(0, "t5_flsel", 0, 0, 0, 1);
    nop(0);          chk(0, "t5_bubble", 0, 0, 0, 1);
    lw(14, 1);
    alu(15, 14, 14, 0); chk(0, "t5_ldst", 1, 0, 3, 1);
    alu(15, 14, 14, 0); chk(0, "t5_ldend", 0, 0, 0, 2);
    nop(1);          chk(0, "t5_ext0", 0, 2, 2, 2);
    nop(1);          chk(0, "t5_ext1", 0, 2, 2, 2);
    nop(1);          chk(0, "t5_ext2", 0, 2, 2, 2);
    alu(16, 15, 14, 0); chk(0, "t5_ext3", 0, 2, 2, 2);
    nop(0);          chk(0, "t5_slots", 0, 1, 0, 2);
    lw(17, 1);
    alu(18, 17, 0, 0);
    rst_n = 1'b0;    chk(0, "t6_rst", 0, 0, 0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    alu(19, 17, 17, 0); chk(0, "t6_rel", 0, 0, 0, 0);
    nop(0);          chk(0, "t6_empty", 0, 0, 0, 0);

    @(posedge clk); #1 rst_n = 1'b0;
    nop(0);          chk(1, "b_reset", 0, 0, 0, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    alu(3, 1, 2, 0);
    alu(4, 3, 3, 0);
    nop(0);          chk(1, "b_mem", 0, 1, 1, 0);
    alu(3, 1, 2, 0);
    nop(0);
    alu(5, 3, 0, 0);
    nop(0);          chk(1, "b_code2", 0, 2, 0, 0);
    alu(20, 1, 2, 0);
    nop(0);
    nop(0);
    alu(21, 20, 0, 0);
    nop(0);          chk(1, "b_wb3", 0, 3, 0, 0);
    lw(2, 8);
    alu(6, 2, 7, 0); chk(1, "b_st1", 1, 0, 4, 0);
    alu(6, 2, 7, 0); chk(1, "b_st2", 1, 0, 0, 1);
    alu(6, 2, 7, 0); chk(1, "b_stend", 0, 0, 0, 2);
    nop(0);          chk(1, "b_fwd", 0, 3, 0, 2);

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
